sample_frame_bank: RTL

Parameterised, double-buffered channel sample bank. It collects one WIDTH-bit sample per channel into a shadow bank, using either addressed or auto-incrementing writes. Once every channel has been written, the whole frame is committed atomically to the output bank. The block sits between the sample acquisition front end and the per-channel signal consumers, so every consumer sees a coherent frame and never a partially updated one.

---
 rtl/sample_frame_bank.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sample_frame_bank.sv
// sample_frame_bank
// Double-buffered per-channel sample bank. Samples are gathered into a shadow
// bank (addressed or auto-incrementing writes). When every channel of the frame
// has been written, the whole shadow bank is copied to the output bank in one
// edge, so downstream consumers only ever see complete, coherent frames.
`timescale 1ns/1ps
module sample_frame_bank #(
    parameter int WIDTH    = 11,
    parameter int CHANNELS = 64,
    parameter int IDX_W    = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      auto_inc,
    input  logic                      frame_start,
    input  logic                      err_clr,
    output logic [CHANNELS*WIDTH-1:0] signals,
    output logic [CHANNELS-1:0]       written_mask,
    output logic                      frame_valid,
    output logic                      frame_done,
    output logic                      idx_err
);

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    // Channel count widened by one bit so wr_idx can be range-checked
    // without truncating CHANNELS when it equals 2^IDX_W.
    localparam logic [IDX_W:0]   CH_COUNT = (IDX_W+1)'(CHANNELS);
    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(CHANNELS - 1);

    state_t                state_q, state_d;
    logic [CHANNELS-1:0]   mask_q, mask_d, mask_base;
    logic [IDX_W-1:0]      ptr_q, ptr_d, ptr_base;
    logic [IDX_W-1:0]      wr_chan;
    logic                  err_q, err_d;
    logic                  valid_q;
    logic                  done_q;
    logic                  accept;
    logic                  idx_ok;
    logic                  wr_en;
    logic                  commit;

    logic [WIDTH-1:0]      shadow_q  [CHANNELS];
    logic [WIDTH-1:0]      signals_q [CHANNELS];

    // Writes are only taken while filling; held low while reset is asserted.
    assign wr_ready = (state_q == ST_FILL) && !rst;
    assign accept   = wr_valid && wr_ready;

    // Next-state logic: frame_start clears mask/pointer before the same-edge
    // write is applied, so a combined pulse+write starts a fresh frame.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        ptr_d     = ptr_q;
        err_d     = err_clr ? 1'b0 : err_q;
        commit    = 1'b0;
        wr_en     = 1'b0;
        mask_base = frame_start ? '0 : mask_q;
        ptr_base  = frame_start ? '0 : ptr_q;
        wr_chan   = auto_inc ? ptr_base : wr_idx;
        idx_ok    = auto_inc || ({1'b0, wr_idx} < CH_COUNT);

        case (state_q)
            ST_FILL: begin
                mask_d = mask_base;
                ptr_d  = ptr_base;
                if (accept) begin
                    if (idx_ok) begin
                        wr_en  = 1'b1;
                        mask_d = mask_base | (CHANNELS'(1) << wr_chan);
                    end else begin
                        // Out-of-range addressed write: dropped, flagged; an
                        // error on the same edge as err_clr takes priority.
                        err_d = 1'b1;
                    end
                    if (auto_inc) begin
                        ptr_d = (ptr_base == PTR_LAST) ? '0 : ptr_base + 1'b1;
                    end
                end
                if (wr_en && (&mask_d)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // frame_start is deliberately ignored here; the commit completes.
                commit  = 1'b1;
                mask_d  = '0;
                ptr_d   = '0;
                state_d = ST_FILL;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            mask_q  <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            valid_q <= valid_q | commit;
            done_q  <= commit;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        // Shadow slot: captures the sample addressed to this channel.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_q[gi] <= '0;
            end else if (wr_en && (wr_chan == IDX_W'(gi))) begin
                shadow_q[gi] <= wr_data;
            end
        end

        // Output slot: loaded from the shadow only on the commit edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                signals_q[gi] <= '0;
            end else if (commit) begin
                signals_q[gi] <= shadow_q[gi];
            end
        end

        assign signals[gi*WIDTH +: WIDTH] = signals_q[gi];
    end

    assign written_mask = mask_q;
    assign frame_valid  = valid_q;
    assign frame_done   = done_q;
    assign idx_err      = err_q;

endmodule
